link_status_tx: RTL and testbench

Host-bound status reporter for the USB link. It counts sample-path events: host bytes written to the sample FIFO, bytes dropped while the FIFO is full, modulator sample reads, and FIFO underruns. It sends fixed 9-byte status packets to the host over the FT245 wrapper's TX simple interface (`tx_data_si`/`tx_valid_si`/`tx_ready_si`), which the RX-only datapath leaves unused. Packets go out periodically or on request.

---
 rtl/link_status_tx.sv | 146 ++++++++++++++
 tb/tb_link_status_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_status_tx.sv
// Host-bound status reporter: counts sample-path events and emits 9-byte
// status packets (sync, seq, flags, counters, XOR checksum) over the FT245 TX path.
module link_status_tx #(
  parameter int unsigned REPORT_PERIOD = 128000000,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid_si,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  input  logic       read_sample,
  input  logic       report_req,
  output logic [7:0] tx_data_si,
  output logic       tx_valid_si,
  input  logic       tx_ready_si,
  output logic       busy
);

  localparam int unsigned   TW = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
  localparam logic [TW-1:0] TC = TW'(REPORT_PERIOD - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [8:0][7:0] pkt_q, pkt_d;
  logic [7:0]      seq_q, seq_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pending_q, pending_d;
  logic            empty_prev_q, empty_prev_d;
  logic [15:0]     wr_cnt_q, wr_cnt_d;
  logic [15:0]     rd_cnt_q, rd_cnt_d;
  logic [15:0]     ovf_cnt_q, ovf_cnt_d;
  logic [7:0]      und_cnt_q, und_cnt_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;

  logic       snap, acc, tc;
  logic       ev_wr, ev_rd, ev_ovf, ev_und;
  logic [7:0] flags, csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pkt_q        <= '0;
      seq_q        <= '0;
      timer_q      <= '0;
      pending_q    <= 1'b0;
      empty_prev_q <= 1'b1;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      ovf_cnt_q    <= '0;
      und_cnt_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pkt_q        <= pkt_d;
      seq_q        <= seq_d;
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      empty_prev_q <= empty_prev_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
      und_cnt_q    <= und_cnt_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
    end
  end

  // Counters and trigger logic run in every state; the snapshot cycle restarts
  // the counters with that cycle's event so nothing is lost or counted twice.
  always_comb begin
    snap         = (state_q == IDLE) && pending_q;
    acc          = tx_valid_q && tx_ready_si;
    tc           = (timer_q == TC);
    timer_d      = tc ? '0 : timer_q + TW'(1);
    pending_d    = snap ? 1'b0 : (pending_q | tc | report_req);
    empty_prev_d = fifo_empty;

    ev_wr  = rx_valid_si & ~fifo_full;
    ev_ovf = rx_valid_si & fifo_full;
    ev_rd  = read_sample;
    ev_und = fifo_empty & ~empty_prev_q;

    if (snap) begin
      wr_cnt_d  = {15'd0, ev_wr};
      rd_cnt_d  = {15'd0, ev_rd};
      ovf_cnt_d = {15'd0, ev_ovf};
      und_cnt_d = {7'd0, ev_und};
    end else begin
      wr_cnt_d  = wr_cnt_q + {15'd0, ev_wr};
      rd_cnt_d  = rd_cnt_q + {15'd0, ev_rd};
      ovf_cnt_d = (ovf_cnt_q == 16'hFFFF) ? ovf_cnt_q : ovf_cnt_q + {15'd0, ev_ovf};
      und_cnt_d = (und_cnt_q == 8'hFF) ? und_cnt_q : und_cnt_q + {7'd0, ev_und};
    end

    flags = {6'b0, fifo_full, fifo_empty};
    csum  = SYNC_BYTE ^ seq_q ^ flags ^ rd_cnt_q[15:8] ^ rd_cnt_q[7:0]
          ^ ovf_cnt_q[15:8] ^ ovf_cnt_q[7:0] ^ und_cnt_q;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pkt_d      = pkt_q;
    seq_d      = seq_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d    = SEND;
          idx_d      = '0;
          pkt_d      = {csum, und_cnt_q, ovf_cnt_q[7:0], ovf_cnt_q[15:8],
                        rd_cnt_q[7:0], rd_cnt_q[15:8], flags, seq_q, SYNC_BYTE};
          tx_valid_d = 1'b1;
          tx_data_d  = SYNC_BYTE;
        end
      end
      SEND: begin
        if (acc) begin
          if (idx_q == 4'd8) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
            seq_d      = seq_q + 8'd1;
          end else begin
            idx_d     = idx_q + 4'd1;
            tx_data_d = pkt_q[idx_q + 4'd1];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_valid_si = tx_valid_q;
  assign tx_data_si  = tx_data_q;
  assign busy        = (state_q == SEND) || snap;

endmodule

// File: tb/tb_link_status_tx.sv
// Bench for link_status_tx: reset/latency vector table, directed corner
// sequences and random traffic, all checked against a packet-queue model.
module tb_link_status_tx;
  localparam int P = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid_si, fifo_full, fifo_empty, read_sample, report_req, tx_ready_si;
  logic [7:0] tx_data_si;
  logic       tx_valid_si, busy;

  link_status_tx #(.REPORT_PERIOD(P), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_valid_si(rx_valid_si), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .read_sample(read_sample), .report_req(report_req),
    .tx_data_si(tx_data_si), .tx_valid_si(tx_valid_si), .tx_ready_si(tx_ready_si),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: counters as plain integers, the packet in flight as a byte queue.
  int  m_rd, m_ovf, m_und, m_tmr, m_seq;
  bit  m_pend, m_eprev;
  byte unsigned mq[$];
  byte unsigned cap[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_rd = 0; m_ovf = 0; m_und = 0; m_tmr = 0; m_seq = 0;
    m_pend = 1'b0; m_eprev = 1'b1;
    mq.delete();
  endfunction

  function automatic void m_step();
    bit snap, acc, tc;
    int e_rd, e_ovf, e_und;
    byte unsigned x;
    e_rd  = int'(read_sample);
    e_ovf = int'(rx_valid_si && fifo_full);
    e_und = int'(fifo_empty && !m_eprev);
    snap  = (mq.size() == 0) && m_pend;
    acc   = (mq.size() > 0) && tx_ready_si;
    tc    = (m_tmr == P - 1);
    m_tmr = tc ? 0 : m_tmr + 1;
    if (acc) begin
      void'(mq.pop_front());
      if (mq.size() == 0) m_seq = (m_seq + 1) % 256;
    end
    if (snap) begin
      mq.push_back(8'hA5);
      mq.push_back(8'(m_seq));
      mq.push_back(8'({fifo_full, fifo_empty}));
      mq.push_back(8'(m_rd / 256));
      mq.push_back(8'(m_rd % 256));
      mq.push_back(8'(m_ovf / 256));
      mq.push_back(8'(m_ovf % 256));
      mq.push_back(8'(m_und));
      x = 8'h00;
      for (int i = 0; i < 8; i++) x = x ^ mq[i];
      mq.push_back(x);
      m_rd = e_rd; m_ovf = e_ovf; m_und = e_und;
      m_pend = 1'b0;
    end else begin
      m_rd  = (m_rd + e_rd) % 65536;
      m_ovf = (m_ovf + e_ovf > 65535) ? 65535 : m_ovf + e_ovf;
      m_und = (m_und + e_und > 255) ? 255 : m_und + e_und;
      m_pend = m_pend || tc || report_req;
    end
    m_eprev = fifo_empty;
  endfunction

  always @(posedge clk) if (!rst) m_step();

  // One clock: record the byte accepted at the coming edge, then check outputs.
  task automatic cyc();
    if (tx_valid_si && tx_ready_si) cap.push_back(tx_data_si);
    @(negedge clk);
    chk("valid", int'(tx_valid_si), int'(mq.size() > 0));
    chk("busy", int'(busy), int'(mq.size() > 0 || m_pend));
    if (mq.size() > 0) chk("data", int'(tx_data_si), int'(mq[0]));
  endtask

  task automatic idle_inputs();
    rx_valid_si = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1;
    read_sample = 1'b0; report_req = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((tx_valid_si || busy) && k < 60) begin cyc(); k++; end
    chk("idle_timeout", int'(k < 60), 1);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!tx_valid_si && k < 60) begin cyc(); k++; end
    chk("valid_timeout", int'(k < 60), 1);
  endtask

  // Packet-level checks independent of cycle timing: sync, checksum, seq step.
  task automatic check_cap(input string nm);
    byte unsigned x;
    for (int p = 0; p + 9 <= cap.size(); p += 9) begin
      x = 8'h00;
      for (int i = 0; i < 9; i++) x = x ^ cap[p + i];
      chk({nm, "_sync"}, int'(cap[p]), 'hA5);
      chk({nm, "_csum"}, int'(x), 0);
      if (p > 0) chk({nm, "_seq"}, int'(cap[p + 1]), (int'(cap[p - 8]) + 1) % 256);
    end
  endtask

  typedef struct {
    bit           req;
    bit           rdy;
    bit           v;
    byte unsigned d;
    bit           b;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1, 1, 0, 8'h00, 1};
    tbl[1]  = '{0, 1, 1, 8'hA5, 1};
    tbl[2]  = '{0, 1, 1, 8'h00, 1};
    tbl[3]  = '{0, 1, 1, 8'h01, 1};
    tbl[4]  = '{0, 1, 1, 8'h00, 1};
    tbl[5]  = '{0, 1, 1, 8'h00, 1};
    tbl[6]  = '{0, 1, 1, 8'h00, 1};
    tbl[7]  = '{0, 1, 1, 8'h00, 1};
    tbl[8]  = '{0, 1, 1, 8'h00, 1};
    tbl[9]  = '{0, 1, 1, 8'hA4, 1};
    tbl[10] = '{0, 1, 0, 8'h00, 0};

    idle_inputs();
    tx_ready_si = 1'b1;
    rst = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(tx_valid_si), 0);
    chk("rst_data", int'(tx_data_si), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // First packet after reset, cycle by cycle.
    for (int i = 0; i < 11; i++) begin
      report_req  = tbl[i].req;
      tx_ready_si = tbl[i].rdy;
      cyc();
      chk($sformatf("tbl%0d_valid", i), int'(tx_valid_si), int'(tbl[i].v));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].b));
      if (tbl[i].v) chk($sformatf("tbl%0d_data", i), int'(tx_data_si), int'(tbl[i].d));
    end

    // Backpressure with ready asserted one cycle in three.
    cap.delete();
    wait_idle();
    report_req = 1'b1; cyc(); report_req = 1'b0;
    for (int i = 0; i < 60; i++) begin tx_ready_si = (i % 3 == 0); cyc(); end
    tx_ready_si = 1'b1;
    repeat (30) cyc();
    chk("bp_len", int'(cap.size() >= 18), 1);
    if (cap.size() >= 9) chk("bp_seq1", int'(cap[1]), 1);
    check_cap("bp");

    // Overflow saturation while a packet is stalled.
    wait_idle();
    cap.delete();
    tx_ready_si = 1'b0; rx_valid_si = 1'b1; fifo_full = 1'b1; fifo_empty = 1'b0;
    wait_valid();
    repeat (70000) cyc();
    rx_valid_si = 1'b0; fifo_full = 1'b0; tx_ready_si = 1'b1;
    repeat (80) cyc();
    chk("sat_len", int'(cap.size() >= 27), 1);
    if (cap.size() >= 27) begin
      chk("sat_ovf_hi", int'(cap[14]), 'hFF);
      chk("sat_ovf_lo", int'(cap[15]), 'hFF);
      chk("sat_clr_hi", int'(cap[23]), 0);
      chk("sat_clr_lo", int'(cap[24]), 0);
    end
    check_cap("sat");

    // 300 sample reads and three empty rising edges inside one period.
    wait_idle();
    cap.delete();
    tx_ready_si = 1'b0; fifo_empty = 1'b0;
    wait_valid();
    for (int i = 0; i < 300; i++) begin
      read_sample = 1'b1; fifo_empty = ((i / 50) % 2) == 1; cyc();
    end
    read_sample = 1'b0; tx_ready_si = 1'b1;
    repeat (80) cyc();
    chk("rd_len", int'(cap.size() >= 18), 1);
    if (cap.size() >= 18) begin
      chk("rd_hi", int'(cap[12]), 'h01);
      chk("rd_lo", int'(cap[13]), 'h2C);
      chk("und", int'(cap[16]), 'h03);
    end
    check_cap("rd");

    // Triggers during a long stall coalesce into one follow-up packet.
    idle_inputs();
    wait_idle();
    cap.delete();
    tx_ready_si = 1'b0;
    repeat (50) cyc();
    tx_ready_si = 1'b1;
    repeat (9) cyc();
    chk("coal_len1", cap.size(), 9);
    chk("coal_snap_busy", int'(busy), 1);
    chk("coal_snap_valid", int'(tx_valid_si), 0);
    repeat (10) cyc();
    chk("coal_len2", cap.size(), 18);
    repeat (20) cyc();
    check_cap("coal");

    // Reset while B4 is presented, then a fresh packet.
    wait_idle();
    cap.delete();
    report_req = 1'b1; cyc(); report_req = 1'b0;
    wait_valid();
    for (int k = 0; cap.size() < 4 && k < 20; k++) cyc();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(tx_valid_si), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_data", int'(tx_data_si), 0);
    m_reset();
    cap.delete();
    @(negedge clk);
    rst = 1'b0;
    report_req = 1'b1; cyc(); report_req = 1'b0;
    wait_valid();
    repeat (12) cyc();
    chk("post_rst_len", int'(cap.size() >= 9), 1);
    if (cap.size() >= 9) begin
      chk("post_rst_b0", int'(cap[0]), 'hA5);
      chk("post_rst_b1", int'(cap[1]), 'h00);
    end

    // Random traffic against the model.
    wait_idle();
    cap.delete();
    for (int i = 0; i < 3000; i++) begin
      rx_valid_si = 1'($urandom % 2);
      fifo_full   = ($urandom % 4) == 0;
      fifo_empty  = ($urandom % 8) == 0;
      read_sample = 1'($urandom % 2);
      report_req  = ($urandom % 16) == 0;
      tx_ready_si = ($urandom % 4) != 0;
      cyc();
    end
    check_cap("rnd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
